genie_delay_arb: RTL



---
 rtl/genie_delay_arb_pkg.sv | 21 ++
 rtl/genie_rr_pick.sv | 32 +++
 rtl/genie_delay_arb.sv | 88 ++++++++
 3 files changed

// File: rtl/genie_delay_arb_pkg.sv
// rtl/genie_delay_arb_pkg.sv - shared types and sizing helpers for the delay-line arbiter
// Purpose: source-index width function and the tagged word layout carried to the delay line.
// Ports: none (package).
package genie_delay_arb_pkg;

    // Source-index width; a single requester still carries a 1-bit tag.
    function automatic int src_width(input int ni);
        return (ni > 1) ? $clog2(ni) : 1;
    endfunction

    localparam int DEF_NI    = 4;
    localparam int DEF_WIDTH = 32;

    // Tagged word as seen at the delay-line input for the default configuration.
    typedef struct packed {
        logic [DEF_WIDTH-1:0]          data;
        logic [src_width(DEF_NI)-1:0]  src;
        logic                          eop;
    } arb_word_t;

endpackage

// File: rtl/genie_rr_pick.sv
// rtl/genie_rr_pick.sv - combinational rotate-priority encoder
// Purpose: pick the first requester after 'last', wrapping from NI-1 to 0.
// Ports: req (request vector), last (most recently served index),
//        grant (one-hot), idx (index of grant), any (some request granted).
module genie_rr_pick
    import genie_delay_arb_pkg::*;
#(
    parameter int NI = 4,
    localparam int SW = src_width(NI)
) (
    input  logic [NI-1:0] req,
    input  logic [SW-1:0] last,
    output logic [NI-1:0] grant,
    output logic [SW-1:0] idx,
    output logic          any
);

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        // Walk offsets 1..NI so 'last' itself is considered last.
        for (int off = 1; off <= NI; off++) begin
            if (!any && req[(int'(last) + off) % NI]) begin
                grant[(int'(last) + off) % NI] = 1'b1;
                idx = SW'((int'(last) + off) % NI);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/genie_delay_arb.sv
// rtl/genie_delay_arb.sv - round-robin arbiter feeding the shared delay line
// Purpose: grant one of NI valid/ready requesters per cycle, tag the word with its
//          source index and hold it in a one-deep output register.
// Optional: GENIE_DELAY_ARB_LOCK_EN keeps the grant on one source until its eop word.
// Ports: clk, reset (sync, active-high); i_data/i_valid/i_eop/o_ready per requester;
//        o_data/o_src/o_eop/o_valid with i_ready toward the delay line.
module genie_delay_arb
    import genie_delay_arb_pkg::*;
#(
    parameter int NI    = 4,
    parameter int WIDTH = 32,
    localparam int SW   = src_width(NI)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NI*WIDTH-1:0] i_data,
    input  logic [NI-1:0]       i_valid,
    input  logic [NI-1:0]       i_eop,
    output logic [NI-1:0]       o_ready,
    output logic [WIDTH-1:0]    o_data,
    output logic [SW-1:0]       o_src,
    output logic                o_eop,
    output logic                o_valid,
    input  logic                i_ready
);

    logic [NI-1:0]    req;
    logic [NI-1:0]    grant;
    logic [SW-1:0]    pick_idx;
    logic             pick_any;
    logic [SW-1:0]    last;
    logic             adv;
    logic             xfer;
    logic [WIDTH-1:0] sel_data;
    logic             sel_eop;

    assign adv = !o_valid || i_ready;

`ifdef GENIE_DELAY_ARB_LOCK_EN
    logic locked;

    // The locked source is always the last one served, so 'last' doubles as the owner.
    assign req = locked ? (i_valid & (NI'(1) << last)) : i_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            locked <= 1'b0;
        end else if (xfer) begin
            locked <= !sel_eop;
        end
    end
`else
    assign req = i_valid;
`endif

    genie_rr_pick #(.NI(NI)) u_pick (
        .req   (req),
        .last  (last),
        .grant (grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Grant only goes to requesting sources, so any grant while advancing is a transfer.
    assign o_ready  = (adv && !reset) ? grant : '0;
    assign xfer     = pick_any && adv && !reset;
    assign sel_data = i_data[int'(pick_idx)*WIDTH +: WIDTH];
    assign sel_eop  = i_eop[pick_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_src   <= '0;
            o_eop   <= 1'b0;
            last    <= SW'(NI - 1);
        end else if (xfer) begin
            o_valid <= 1'b1;
            o_data  <= sel_data;
            o_src   <= pick_idx;
            o_eop   <= sel_eop;
            last    <= pick_idx;
        end else if (adv) begin
            o_valid <= 1'b0;
        end
    end

endmodule
